// File: rtl/rnea_fwd_sched_pkg.sv
// Shared definitions for the RNEA forward-pass scheduler: state encoding,
// link-index width and the default base-frame gravity term.
package rnea_fwd_sched_pkg;

  localparam int LINK_W = 3;

  // 9.81 in Q16.16, the base-frame linear Z acceleration fed to link 1
  localparam logic signed [31:0] GRAV_DEFAULT = 32'sh0009CE80;

  // Number of spatial-vector components (AX, AY, AZ, LX, LY, LZ)
  localparam int NUM_COMP = 6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_S1   = 3'd1,
    ST_S2   = 3'd2,
    ST_S3   = 3'd3,
    ST_DONE = 3'd4
  } fsm_state_t;

  typedef logic [LINK_W-1:0] link_t;

endpackage

// File: rtl/rnea_fwd_sched.sv
// RNEA forward-pass scheduler. Walks links 1..NUM_LINKS through three
// datapath stages each, forwards joint data, feeds parent velocity and
// acceleration, and emits one force write per link.
// Optional feature: define RNEA_FWD_VA_WR_EN to add a velocity/acceleration
// write port strobed alongside the force write.
module rnea_fwd_sched
  import rnea_fwd_sched_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int DECIMAL_BITS = 16,
  parameter int NUM_LINKS    = 7,
  parameter logic signed [WIDTH-1:0] GRAV = GRAV_DEFAULT
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [2:0]              jnt_link,
  input  logic signed [WIDTH-1:0] sinq_in,
  input  logic signed [WIDTH-1:0] cosq_in,
  input  logic signed [WIDTH-1:0] qd_in,
  input  logic signed [WIDTH-1:0] qdd_in,
  output logic                    s1_bool,
  output logic                    s2_bool,
  output logic                    s3_bool,
  output logic [2:0]              link_out,
  output logic signed [WIDTH-1:0] sinq_out,
  output logic signed [WIDTH-1:0] cosq_out,
  output logic signed [WIDTH-1:0] qd_out,
  output logic signed [WIDTH-1:0] qdd_out,
  output logic signed [WIDTH-1:0] v_prev_AX,
  output logic signed [WIDTH-1:0] v_prev_AY,
  output logic signed [WIDTH-1:0] v_prev_AZ,
  output logic signed [WIDTH-1:0] v_prev_LX,
  output logic signed [WIDTH-1:0] v_prev_LY,
  output logic signed [WIDTH-1:0] v_prev_LZ,
  output logic signed [WIDTH-1:0] a_prev_AX,
  output logic signed [WIDTH-1:0] a_prev_AY,
  output logic signed [WIDTH-1:0] a_prev_AZ,
  output logic signed [WIDTH-1:0] a_prev_LX,
  output logic signed [WIDTH-1:0] a_prev_LY,
  output logic signed [WIDTH-1:0] a_prev_LZ,
  input  logic signed [WIDTH-1:0] v_curr_AX,
  input  logic signed [WIDTH-1:0] v_curr_AY,
  input  logic signed [WIDTH-1:0] v_curr_AZ,
  input  logic signed [WIDTH-1:0] v_curr_LX,
  input  logic signed [WIDTH-1:0] v_curr_LY,
  input  logic signed [WIDTH-1:0] v_curr_LZ,
  input  logic signed [WIDTH-1:0] a_curr_AX,
  input  logic signed [WIDTH-1:0] a_curr_AY,
  input  logic signed [WIDTH-1:0] a_curr_AZ,
  input  logic signed [WIDTH-1:0] a_curr_LX,
  input  logic signed [WIDTH-1:0] a_curr_LY,
  input  logic signed [WIDTH-1:0] a_curr_LZ,
  input  logic signed [WIDTH-1:0] f_curr_AX,
  input  logic signed [WIDTH-1:0] f_curr_AY,
  input  logic signed [WIDTH-1:0] f_curr_AZ,
  input  logic signed [WIDTH-1:0] f_curr_LX,
  input  logic signed [WIDTH-1:0] f_curr_LY,
  input  logic signed [WIDTH-1:0] f_curr_LZ,
`ifdef RNEA_FWD_VA_WR_EN
  output logic                    va_wr_en,
  output logic [2:0]              va_wr_link,
  output logic signed [WIDTH-1:0] va_wr_v_AX,
  output logic signed [WIDTH-1:0] va_wr_v_AY,
  output logic signed [WIDTH-1:0] va_wr_v_AZ,
  output logic signed [WIDTH-1:0] va_wr_v_LX,
  output logic signed [WIDTH-1:0] va_wr_v_LY,
  output logic signed [WIDTH-1:0] va_wr_v_LZ,
  output logic signed [WIDTH-1:0] va_wr_a_AX,
  output logic signed [WIDTH-1:0] va_wr_a_AY,
  output logic signed [WIDTH-1:0] va_wr_a_AZ,
  output logic signed [WIDTH-1:0] va_wr_a_LX,
  output logic signed [WIDTH-1:0] va_wr_a_LY,
  output logic signed [WIDTH-1:0] va_wr_a_LZ,
`endif
  output logic                    f_wr_en,
  output logic [2:0]              f_wr_link,
  output logic signed [WIDTH-1:0] f_wr_AX,
  output logic signed [WIDTH-1:0] f_wr_AY,
  output logic signed [WIDTH-1:0] f_wr_AZ,
  output logic signed [WIDTH-1:0] f_wr_LX,
  output logic signed [WIDTH-1:0] f_wr_LY,
  output logic signed [WIDTH-1:0] f_wr_LZ
);

  // Reject configurations the 3-bit link index or the Q format cannot hold
  if ((NUM_LINKS < 1) || (NUM_LINKS > 7) ||
      (DECIMAL_BITS < 0) || (DECIMAL_BITS >= WIDTH)) begin : g_bad_cfg
    $error("rnea_fwd_sched: unsupported NUM_LINKS or DECIMAL_BITS");
  end

  fsm_state_t state;
  link_t      link;
  link_t      f_link_q;
  logic       f_wr_en_q;

  // Component index 0..5 maps to AX, AY, AZ, LX, LY, LZ
  logic [NUM_COMP-1:0][WIDTH-1:0] v_vec, a_vec, f_vec;
  logic [NUM_COMP-1:0][WIDTH-1:0] v_q, a_q, f_q;
  logic [NUM_COMP-1:0][WIDTH-1:0] v_prev_vec, a_prev_vec;

  logic last_link;
  logic link_gt1;

  assign v_vec = {v_curr_LZ, v_curr_LY, v_curr_LX, v_curr_AZ, v_curr_AY, v_curr_AX};
  assign a_vec = {a_curr_LZ, a_curr_LY, a_curr_LX, a_curr_AZ, a_curr_AY, a_curr_AX};
  assign f_vec = {f_curr_LZ, f_curr_LY, f_curr_LX, f_curr_AZ, f_curr_AY, f_curr_AX};

  assign last_link = (link == link_t'(NUM_LINKS));
  assign link_gt1  = (link > link_t'(1));

  // Sequencer: stage strobes, busy and done are registered with the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      link    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      s1_bool <= 1'b0;
      s2_bool <= 1'b0;
      s3_bool <= 1'b0;
    end else begin
      done    <= 1'b0;
      s1_bool <= 1'b0;
      s2_bool <= 1'b0;
      s3_bool <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_S1;
            link    <= link_t'(1);
            busy    <= 1'b1;
            s1_bool <= 1'b1;
          end
        end
        ST_S1: begin
          state   <= ST_S2;
          s2_bool <= 1'b1;
        end
        ST_S2: begin
          state   <= ST_S3;
          s3_bool <= 1'b1;
        end
        ST_S3: begin
          if (last_link) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            state   <= ST_S1;
            link    <= link + link_t'(1);
            s1_bool <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          link  <= '0;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          link  <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Capture datapath results at the end of S3 and raise the write strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q       <= '0;
      a_q       <= '0;
      f_q       <= '0;
      f_link_q  <= '0;
      f_wr_en_q <= 1'b0;
    end else begin
      f_wr_en_q <= (state == ST_S3);
      if (state == ST_S3) begin
        v_q      <= v_vec;
        a_q      <= a_vec;
        f_q      <= f_vec;
        f_link_q <= link;
      end
    end
  end

  // Link 1 sees the base frame at rest under gravity; later links see the parent
  always_comb begin
    v_prev_vec = '0;
    a_prev_vec = '0;
    if (link_gt1) begin
      v_prev_vec = v_q;
      a_prev_vec = a_q;
    end else begin
      a_prev_vec[5] = GRAV;
    end
  end

  assign jnt_link = link;
  assign link_out = link;

  assign sinq_out = s1_bool ? sinq_in : '0;
  assign cosq_out = s1_bool ? cosq_in : '0;
  assign qd_out   = s1_bool ? qd_in   : '0;
  assign qdd_out  = s1_bool ? qdd_in  : '0;

  assign v_prev_AX = v_prev_vec[0];
  assign v_prev_AY = v_prev_vec[1];
  assign v_prev_AZ = v_prev_vec[2];
  assign v_prev_LX = v_prev_vec[3];
  assign v_prev_LY = v_prev_vec[4];
  assign v_prev_LZ = v_prev_vec[5];
  assign a_prev_AX = a_prev_vec[0];
  assign a_prev_AY = a_prev_vec[1];
  assign a_prev_AZ = a_prev_vec[2];
  assign a_prev_LX = a_prev_vec[3];
  assign a_prev_LY = a_prev_vec[4];
  assign a_prev_LZ = a_prev_vec[5];

  assign f_wr_en   = f_wr_en_q;
  assign f_wr_link = f_link_q;
  assign f_wr_AX   = f_q[0];
  assign f_wr_AY   = f_q[1];
  assign f_wr_AZ   = f_q[2];
  assign f_wr_LX   = f_q[3];
  assign f_wr_LY   = f_q[4];
  assign f_wr_LZ   = f_q[5];

`ifdef RNEA_FWD_VA_WR_EN
  assign va_wr_en   = f_wr_en_q;
  assign va_wr_link = f_link_q;
  assign va_wr_v_AX = v_q[0];
  assign va_wr_v_AY = v_q[1];
  assign va_wr_v_AZ = v_q[2];
  assign va_wr_v_LX = v_q[3];
  assign va_wr_v_LY = v_q[4];
  assign va_wr_v_LZ = v_q[5];
  assign va_wr_a_AX = a_q[0];
  assign va_wr_a_AY = a_q[1];
  assign va_wr_a_AZ = a_q[2];
  assign va_wr_a_LX = a_q[3];
  assign va_wr_a_LY = a_q[4];
  assign va_wr_a_LZ = a_q[5];
`endif

endmodule

// File: tb/tb_rnea_fwd_sched.sv
// Directed bench for rnea_fwd_sched (default build, NUM_LINKS=7). A small
// behavioural datapath returns link-dependent vectors so captures and
// parent forwarding can be predicted by hand.
module tb_rnea_fwd_sched;

  localparam logic [31:0] GRAV_Q16 = 32'h0009CE80;

  logic clk;
  logic rst_n;
  logic start;
  logic busy, done;
  logic [2:0] jnt_link, link_out, f_wr_link;
  logic s1_bool, s2_bool, s3_bool, f_wr_en;
  logic signed [31:0] sinq_in, cosq_in, qd_in, qdd_in;
  logic signed [31:0] sinq_out, cosq_out, qd_out, qdd_out;
  logic signed [31:0] v_prev_AX, v_prev_AY, v_prev_AZ, v_prev_LX, v_prev_LY, v_prev_LZ;
  logic signed [31:0] a_prev_AX, a_prev_AY, a_prev_AZ, a_prev_LX, a_prev_LY, a_prev_LZ;
  logic signed [31:0] v_curr_AX, v_curr_AY, v_curr_AZ, v_curr_LX, v_curr_LY, v_curr_LZ;
  logic signed [31:0] a_curr_AX, a_curr_AY, a_curr_AZ, a_curr_LX, a_curr_LY, a_curr_LZ;
  logic signed [31:0] f_curr_AX, f_curr_AY, f_curr_AZ, f_curr_LX, f_curr_LY, f_curr_LZ;
  logic signed [31:0] f_wr_AX, f_wr_AY, f_wr_AZ, f_wr_LX, f_wr_LY, f_wr_LZ;

  int n_cmp = 0;
  int n_bad = 0;

  rnea_fwd_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .jnt_link(jnt_link),
    .sinq_in(sinq_in), .cosq_in(cosq_in), .qd_in(qd_in), .qdd_in(qdd_in),
    .s1_bool(s1_bool), .s2_bool(s2_bool), .s3_bool(s3_bool), .link_out(link_out),
    .sinq_out(sinq_out), .cosq_out(cosq_out), .qd_out(qd_out), .qdd_out(qdd_out),
    .v_prev_AX(v_prev_AX), .v_prev_AY(v_prev_AY), .v_prev_AZ(v_prev_AZ),
    .v_prev_LX(v_prev_LX), .v_prev_LY(v_prev_LY), .v_prev_LZ(v_prev_LZ),
    .a_prev_AX(a_prev_AX), .a_prev_AY(a_prev_AY), .a_prev_AZ(a_prev_AZ),
    .a_prev_LX(a_prev_LX), .a_prev_LY(a_prev_LY), .a_prev_LZ(a_prev_LZ),
    .v_curr_AX(v_curr_AX), .v_curr_AY(v_curr_AY), .v_curr_AZ(v_curr_AZ),
    .v_curr_LX(v_curr_LX), .v_curr_LY(v_curr_LY), .v_curr_LZ(v_curr_LZ),
    .a_curr_AX(a_curr_AX), .a_curr_AY(a_curr_AY), .a_curr_AZ(a_curr_AZ),
    .a_curr_LX(a_curr_LX), .a_curr_LY(a_curr_LY), .a_curr_LZ(a_curr_LZ),
    .f_curr_AX(f_curr_AX), .f_curr_AY(f_curr_AY), .f_curr_AZ(f_curr_AZ),
    .f_curr_LX(f_curr_LX), .f_curr_LY(f_curr_LY), .f_curr_LZ(f_curr_LZ),
    .f_wr_en(f_wr_en), .f_wr_link(f_wr_link),
    .f_wr_AX(f_wr_AX), .f_wr_AY(f_wr_AY), .f_wr_AZ(f_wr_AZ),
    .f_wr_LX(f_wr_LX), .f_wr_LY(f_wr_LY), .f_wr_LZ(f_wr_LZ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stand-in: component k of link l
  function automatic logic [31:0] v_model(input int l, input int k);
    return 32'((l << 16) + k);
  endfunction

  function automatic logic [31:0] a_model(input int l, input int k);
    return 32'((l << 8) + k + 32'h40);
  endfunction

  function automatic logic [31:0] f_model(input int l, input int k);
    return 32'(l + (5 - k) * 32'h1000);
  endfunction

  function automatic logic [31:0] j_model(input int l, input int k);
    return 32'((k + 1) * 32'h100 + l);
  endfunction

  // Joint data is looked up by jnt_link, results by link_out
  always_comb begin
    sinq_in   = j_model(int'(jnt_link), 0);
    cosq_in   = j_model(int'(jnt_link), 1);
    qd_in     = j_model(int'(jnt_link), 2);
    qdd_in    = j_model(int'(jnt_link), 3);
    v_curr_AX = v_model(int'(link_out), 0);
    v_curr_AY = v_model(int'(link_out), 1);
    v_curr_AZ = v_model(int'(link_out), 2);
    v_curr_LX = v_model(int'(link_out), 3);
    v_curr_LY = v_model(int'(link_out), 4);
    v_curr_LZ = v_model(int'(link_out), 5);
    a_curr_AX = a_model(int'(link_out), 0);
    a_curr_AY = a_model(int'(link_out), 1);
    a_curr_AZ = a_model(int'(link_out), 2);
    a_curr_LX = a_model(int'(link_out), 3);
    a_curr_LY = a_model(int'(link_out), 4);
    a_curr_LZ = a_model(int'(link_out), 5);
    f_curr_AX = f_model(int'(link_out), 0);
    f_curr_AY = f_model(int'(link_out), 1);
    f_curr_AZ = f_model(int'(link_out), 2);
    f_curr_LX = f_model(int'(link_out), 3);
    f_curr_LY = f_model(int'(link_out), 4);
    f_curr_LZ = f_model(int'(link_out), 5);
  end

  // Pulse start; returns at the negedge where the first S1 is visible
  task automatic begin_pass();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Let the current pass drain, bounded
  task automatic wait_idle();
    int k;
    k = 0;
    while (busy === 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (busy !== 1'b0) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, k);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, f_wr_en, s1_bool, s2_bool, s3_bool} !== 6'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_flags: got %b required 000000",
               {busy, done, f_wr_en, s1_bool, s2_bool, s3_bool});
    end
    n_cmp++;
    if (link_out !== 3'd0 || jnt_link !== 3'd0) begin
      n_bad++;
      $display("[TB] FAIL reset_link: got %0d/%0d required 0/0", link_out, jnt_link);
    end
    n_cmp++;
    if (f_wr_LZ !== 32'h0 || f_wr_link !== 3'd0) begin
      n_bad++;
      $display("[TB] FAIL reset_capture: f_wr_LZ=%0h link=%0d required 0/0", f_wr_LZ, f_wr_link);
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_idle_busy: got %b required 0", busy);
    end
  endtask

  // Stage rotation, busy, done timing for one full pass
  task automatic test_schedule();
    int ph, l;
    logic [2:0] exp_s;
    begin_pass();
    for (int cyc = 1; cyc <= 22; cyc++) begin
      if (cyc > 1) @(negedge clk);
      ph = (cyc - 1) % 3;
      l  = (cyc - 1) / 3 + 1;
      exp_s = (cyc == 22) ? 3'b000 : (3'b100 >> ph);
      n_cmp++;
      if ({s1_bool, s2_bool, s3_bool} !== exp_s) begin
        n_bad++;
        $display("[TB] FAIL sched_stage c%0d: got %b required %b", cyc,
                 {s1_bool, s2_bool, s3_bool}, exp_s);
      end
      n_cmp++;
      if (busy !== 1'b1 || done !== (cyc == 22)) begin
        n_bad++;
        $display("[TB] FAIL sched_busy_done c%0d: got %b%b required 1%b", cyc, busy, done,
                 (cyc == 22));
      end
      if (cyc < 22) begin
        n_cmp++;
        if (link_out !== 3'(l) || jnt_link !== 3'(l)) begin
          n_bad++;
          $display("[TB] FAIL sched_link c%0d: got %0d/%0d required %0d", cyc, link_out,
                   jnt_link, l);
        end
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, done, s1_bool, s2_bool, s3_bool} !== 5'b0 || link_out !== 3'd0) begin
      n_bad++;
      $display("[TB] FAIL sched_after: flags %b link %0d required 00000/0",
               {busy, done, s1_bool, s2_bool, s3_bool}, link_out);
    end
  endtask

  // Link 1 parent is the base frame; joint data forwarded only in S1
  task automatic test_base_frame();
    begin_pass();
    n_cmp++;
    if ({v_prev_AX, v_prev_AY, v_prev_AZ, v_prev_LX, v_prev_LY, v_prev_LZ,
         a_prev_AX, a_prev_AY, a_prev_AZ, a_prev_LX, a_prev_LY} !== 352'h0) begin
      n_bad++;
      $display("[TB] FAIL base_zero: v_prev_AX=%0h a_prev_AX=%0h required all 0",
               v_prev_AX, a_prev_AX);
    end
    n_cmp++;
    if (a_prev_LZ !== GRAV_Q16) begin
      n_bad++;
      $display("[TB] FAIL base_grav: got %0h required %0h", a_prev_LZ, GRAV_Q16);
    end
    n_cmp++;
    if ({sinq_out, cosq_out, qd_out, qdd_out} !==
        {32'h101, 32'h201, 32'h301, 32'h401}) begin
      n_bad++;
      $display("[TB] FAIL joint_s1: got %0h %0h %0h %0h required 101 201 301 401",
               sinq_out, cosq_out, qd_out, qdd_out);
    end
    @(negedge clk);
    n_cmp++;
    if ({sinq_out, cosq_out, qd_out, qdd_out} !== 128'h0) begin
      n_bad++;
      $display("[TB] FAIL joint_s2: got %0h %0h %0h %0h required 0", sinq_out, cosq_out,
               qd_out, qdd_out);
    end
    wait_idle();
  endtask

  // Link 3 S1 sees link 2's captured velocity and acceleration
  task automatic test_prev_chain();
    begin_pass();
    repeat (6) @(negedge clk);
    n_cmp++;
    if (v_prev_AX !== 32'h20000) begin
      n_bad++;
      $display("[TB] FAIL chain_v_AX: got %0h required 20000", v_prev_AX);
    end
    n_cmp++;
    if (v_prev_LZ !== 32'h20005 || a_prev_LZ !== 32'h245 || a_prev_AX !== 32'h240) begin
      n_bad++;
      $display("[TB] FAIL chain_va: v_LZ=%0h a_LZ=%0h a_AX=%0h required 20005 245 240",
               v_prev_LZ, a_prev_LZ, a_prev_AX);
    end
    n_cmp++;
    if (sinq_out !== 32'h103) begin
      n_bad++;
      $display("[TB] FAIL chain_sinq: got %0h required 103", sinq_out);
    end
    wait_idle();
  endtask

  // One force write per link, the cycle after each S3, last one with done
  task automatic test_force_write();
    int pulses, l;
    logic exp_en;
    pulses = 0;
    begin_pass();
    for (int cyc = 1; cyc <= 23; cyc++) begin
      if (cyc > 1) @(negedge clk);
      exp_en = (cyc >= 4) && (cyc <= 22) && ((cyc - 1) % 3 == 0);
      l = (cyc - 1) / 3;
      n_cmp++;
      if (f_wr_en !== exp_en) begin
        n_bad++;
        $display("[TB] FAIL fwr_en c%0d: got %b required %b", cyc, f_wr_en, exp_en);
      end
      if (f_wr_en === 1'b1) pulses++;
      if (exp_en) begin
        n_cmp++;
        if (f_wr_link !== 3'(l) || f_wr_LZ !== 32'(l) || f_wr_AX !== f_model(l, 0)) begin
          n_bad++;
          $display("[TB] FAIL fwr_data c%0d: link %0d LZ %0h AX %0h required %0d %0h %0h",
                   cyc, f_wr_link, f_wr_LZ, f_wr_AX, l, l, f_model(l, 0));
        end
      end
      if (cyc == 22) begin
        n_cmp++;
        if (done !== 1'b1 || f_wr_en !== 1'b1) begin
          n_bad++;
          $display("[TB] FAIL fwr_last_with_done: done %b en %b required 1 1", done, f_wr_en);
        end
      end
    end
    n_cmp++;
    if (pulses !== 7) begin
      n_bad++;
      $display("[TB] FAIL fwr_count: got %0d required 7", pulses);
    end
  endtask

  // start held high: ignored during the pass and in DONE, accepted in IDLE
  task automatic test_start_held();
    @(negedge clk) start = 1'b1;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      @(negedge clk);
      if (cyc == 4) begin
        n_cmp++;
        if (link_out !== 3'd2 || s1_bool !== 1'b1) begin
          n_bad++;
          $display("[TB] FAIL held_no_restart: link %0d s1 %b required 2 1", link_out, s1_bool);
        end
      end
      if (cyc == 22) begin
        n_cmp++;
        if (done !== 1'b1) begin
          n_bad++;
          $display("[TB] FAIL held_done: got %b required 1", done);
        end
      end
      if (cyc == 23) begin
        n_cmp++;
        if (busy !== 1'b0 || s1_bool !== 1'b0) begin
          n_bad++;
          $display("[TB] FAIL held_idle: busy %b s1 %b required 0 0", busy, s1_bool);
        end
      end
      if (cyc == 24) begin
        n_cmp++;
        if (busy !== 1'b1 || s1_bool !== 1'b1 || link_out !== 3'd1) begin
          n_bad++;
          $display("[TB] FAIL held_restart: busy %b s1 %b link %0d required 1 1 1", busy,
                   s1_bool, link_out);
        end
      end
    end
    start = 1'b0;
    wait_idle();
  endtask

  // Reset during link 4 S2 abandons the pass; a fresh pass is clean
  task automatic test_reset_mid_pass();
    logic saw_evt;
    begin_pass();
    repeat (10) @(negedge clk);
    n_cmp++;
    if (link_out !== 3'd4 || s2_bool !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL mid_position: link %0d s2 %b required 4 1", link_out, s2_bool);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, f_wr_en, s1_bool, s2_bool, s3_bool} !== 6'b0 || link_out !== 3'd0 ||
        f_wr_LZ !== 32'h0) begin
      n_bad++;
      $display("[TB] FAIL mid_async: flags %b link %0d f_wr_LZ %0h required 0",
               {busy, done, f_wr_en, s1_bool, s2_bool, s3_bool}, link_out, f_wr_LZ);
    end
    @(negedge clk) rst_n = 1'b1;
    saw_evt = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || f_wr_en === 1'b1 || busy === 1'b1) saw_evt = 1'b1;
    end
    n_cmp++;
    if (saw_evt !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL mid_abandon: activity after reset %b required 0", saw_evt);
    end
    test_schedule();
  endtask

  initial begin
    start = 1'b0;
    test_reset();
    test_schedule();
    test_base_frame();
    test_prev_chain();
    test_force_write();
    test_start_held();
    test_reset_mid_pass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/rnea_fwd_sched.md
RNEA_FWD_SCHED -- requirements
Module: rnea_fwd_sched

Interface
REQ-001 Parameters SHALL be: WIDTH, 32, fixed-point word width; DECIMAL_BITS, 16, fraction bits; NUM_LINKS, 7, links per pass (1..7); GRAV, 32'sh0009CE80, base-frame LZ acceleration (9.81 in Q16.16).
REQ-002 Ports SHALL be, as name direction width meaning:
- clk in 1 clock
- rst_n in 1 asynchronous active-low reset
- start in 1 begin forward pass (IDLE only)
- busy out 1 pass in progress
- done out 1 one-cycle pulse, pass complete
- jnt_link out 3 link whose joint data is requested
- sinq_in, cosq_in, qd_in, qdd_in in WIDTH signed joint data for jnt_link, same cycle
- s1_bool, s2_bool, s3_bool out 1 stage enables to the link datapath
- link_out out 3 link index to the datapath
- sinq_out, cosq_out, qd_out, qdd_out out WIDTH signed joint data to the datapath
- v_prev_*, a_prev_* (AX,AY,AZ,LX,LY,LZ) out WIDTH signed parent velocity/acceleration
- v_curr_*, a_curr_*, f_curr_* (AX..LZ) in WIDTH signed datapath results
- f_wr_en out 1 force write strobe
- f_wr_link out 3 link of written force
- f_wr_* (AX..LZ) out WIDTH signed force to backward-pass store

Function
REQ-003 FSM states SHALL be IDLE, S1, S2, S3, DONE, one cycle each in S1/S2/S3/DONE.
REQ-004 IDLE SHALL go to S1 with link=1 when start=1; start SHALL be ignored in every other state.
REQ-005 S1->S2->S3 SHALL be unconditional; S3 SHALL go to DONE when link==NUM_LINKS, otherwise to S1 with link+1.
REQ-006 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-007 s1_bool, s2_bool and s3_bool SHALL be 1 only in S1, S2 and S3 respectively; all three SHALL be 0 in IDLE and DONE.
REQ-008 busy SHALL be 1 in S1, S2, S3 and DONE, and 0 in IDLE.
REQ-009 jnt_link and link_out SHALL equal the current link register; in IDLE they SHALL be 0.
REQ-010 sinq/cosq/qd/qdd_out SHALL pass through the inputs combinationally in S1, and SHALL be 0 otherwise.
REQ-011 For link 1, v_prev SHALL be all zero and a_prev SHALL be {0,0,0,0,0,GRAV}; for link>1, v_prev/a_prev SHALL be the registered v_curr/a_curr captured in the previous S3.
REQ-012 In S3, on the rising edge, the block SHALL register v_curr and a_curr, and SHALL register f_curr together with its link number.
REQ-013 f_wr_en SHALL pulse for one cycle, in the cycle after each S3, with f_wr_link and f_wr_* holding the captured values.
REQ-014 A pass SHALL take 3*NUM_LINKS+1 cycles from the first S1 to DONE inclusive (22 for NUM_LINKS=7).
REQ-015 The last f_wr_en pulse SHALL coincide with done.
REQ-016 start asserted in the DONE cycle SHALL be ignored; start asserted in the following IDLE cycle SHALL be accepted.
REQ-017 All datapath values SHALL be moved without arithmetic or width change.

Reset
REQ-018 rst_n=0 SHALL force, asynchronously, state=IDLE, link=0 and all captured registers to 0.
REQ-019 While rst_n=0, busy, done, f_wr_en and the stage booleans SHALL be 0.
REQ-020 Reset mid-pass SHALL abandon the pass with no further f_wr_en pulse and no done pulse.

Configuration
REQ-021 With RNEA_FWD_VA_WR_EN defined, the block SHALL add outputs va_wr_en, va_wr_link, va_wr_v_* and va_wr_a_*, strobed exactly like f_wr_en with the captured v/a.
REQ-022 Without RNEA_FWD_VA_WR_EN, those ports SHALL NOT exist.

Structure
REQ-023 A shared package SHALL hold the state encoding, the GRAV default and the link-index width (3).
REQ-024 The block SHALL use no sub-modules; the FSM and capture registers SHALL live in one module.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Reset then start pulse, NUM_LINKS=7 -> s1/s2/s3 rotate 7 times, done at cycle 22, busy low the next cycle.
- Link 1 S1 -> a_prev_LZ=0x0009CE80, all other v_prev/a_prev 0.
- Datapath model returns v_curr_AX=link*0x10000 -> link 3 S1 shows v_prev_AX=0x20000.
- f_curr_LZ=link -> seven f_wr_en pulses with f_wr_link 1..7 and f_wr_LZ 1..7.
- start held high throughout -> no restart until IDLE, then a second pass begins.
- rst_n low during link 4 S2 -> immediate IDLE, no done; a new start gives a clean 22-cycle pass.
